// File: rtl/rf_writeback_if.sv
// Register-file write-back bundle: ALU results, load returns, the merged write port and decode hazard probes.
// master = upstream/decode side, slave = the write-back arbiter.
interface rf_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        en;
  logic        wb_full;
  logic [4:0]  chk_adr1;
  logic [4:0]  chk_adr2;
  logic        chk_hit1;
  logic        chk_hit2;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr,
    output chk_adr1, chk_adr2,
    input  ld_ready, wa, wd, en, wb_full, chk_hit1, chk_hit2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr,
    input  chk_adr1, chk_adr2,
    output ld_ready, wa, wd, en, wb_full, chk_hit1, chk_hit2
  );
endinterface

// File: rtl/rf_writeback.sv
// Merges ALU results (1-cycle) and extended load returns (FIFO, >=2 cycles) onto one registered RF write port.
// ALU always wins; loads back-pressure via ld_ready=!full; chk_hit flags pending writes to decode sources.
module rf_writeback #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  rf_writeback_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          en_q, en_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  ent_t          head;
  logic [AW-1:0] off;
  logic          hit1;
  logic          hit2;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = wb.ld_valid && !full;
  assign pop   = !wb.alu_valid && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    en_d     = 1'b0;
    head     = mem_q[rd_ptr_q];

    if (push) begin
      mem_d[wr_ptr_q] = {wb.ld_rd, extend(wb.ld_data, wb.ld_funct3, wb.ld_addr)};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    // x0 targets still move wa/wd; only the enable is suppressed.
    if (wb.alu_valid) begin
      wa_d = wb.alu_rd;
      wd_d = wb.alu_data;
      en_d = (wb.alu_rd != 5'd0);
    end else if (!empty) begin
      wa_d     = head.rd;
      wd_d     = head.data;
      en_d     = (head.rd != 5'd0);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Hazards come only from queued entries and the write being presented now.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if ({1'b0, off} < cnt_q) begin
        if (mem_q[i].rd == wb.chk_adr1) hit1 = 1'b1;
        if (mem_q[i].rd == wb.chk_adr2) hit2 = 1'b1;
      end
    end
    if (en_q && (wa_q == wb.chk_adr1)) hit1 = 1'b1;
    if (en_q && (wa_q == wb.chk_adr2)) hit2 = 1'b1;
    if (wb.chk_adr1 == 5'd0) hit1 = 1'b0;
    if (wb.chk_adr2 == 5'd0) hit2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      en_q     <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      en_q     <= en_d;
    end
  end

  assign wb.ld_ready = !full;
  assign wb.wb_full  = full;
  assign wb.wa       = wa_q;
  assign wb.wd       = wd_q;
  assign wb.en       = en_q;
  assign wb.chk_hit1 = hit1;
  assign wb.chk_hit2 = hit2;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, extension, ALU priority, full/wrap, x0 and push+pop cases.
module tb_rf_writeback;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  rf_writeback_if ifc ();

  rf_writeback #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.alu_valid = 1'b0;
    ifc.alu_rd    = 5'd0;
    ifc.alu_data  = 32'd0;
    ifc.ld_valid  = 1'b0;
    ifc.ld_rd     = 5'd0;
    ifc.ld_data   = 32'd0;
    ifc.ld_funct3 = 3'b010;
    ifc.ld_addr   = 2'd0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] d);
    ifc.ld_valid  = 1'b1;
    ifc.ld_rd     = rd;
    ifc.ld_data   = d;
    ifc.ld_funct3 = 3'b010;
    ifc.ld_addr   = 2'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    ifc.alu_valid = 1'b1;
    ifc.alu_rd    = rd;
    ifc.alu_data  = d;
  endtask

  task automatic test_reset();
    ifc.chk_adr1 = 5'd5;
    ifc.chk_adr2 = 5'd0;
    #3;
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", ifc.en); end
    total++; if (ifc.wa !== 5'd0) begin bad++; $display("FAIL rst_wa got=%0d exp=0", ifc.wa); end
    total++; if (ifc.wd !== 32'd0) begin bad++; $display("FAIL rst_wd got=%h exp=0", ifc.wd); end
    total++; if (ifc.ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ld_ready got=%b exp=1", ifc.ld_ready); end
    total++; if (ifc.wb_full !== 1'b0) begin bad++; $display("FAIL rst_wb_full got=%b exp=0", ifc.wb_full); end
    total++; if (ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL rst_hit1 got=%b exp=0", ifc.chk_hit1); end
    total++; if (ifc.chk_hit2 !== 1'b0) begin bad++; $display("FAIL rst_hit2 got=%b exp=0", ifc.chk_hit2); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    ifc.chk_adr1 = 5'd10;
    alu(5'd1, 32'h1111);
    for (int j = 0; j < 3; j++) begin
      load(5'(10 + j), 32'h100 + 32'(j));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b exp=0", ifc.en); end
    total++; if (ifc.ld_ready !== 1'b1) begin bad++; $display("FAIL midrst_ld_ready got=%b exp=1", ifc.ld_ready); end
    total++; if (ifc.wb_full !== 1'b0) begin bad++; $display("FAIL midrst_wb_full got=%b exp=0", ifc.wb_full); end
    total++; if (ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL midrst_hit1 got=%b exp=0", ifc.chk_hit1); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL midrst_stale k=%0d en got=%b exp=0 wa=%0d", k, ifc.en, ifc.wa); end
    end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s [10];
    logic [1:0]  ads [10];
    logic [31:0] exp_wd [10];
    f3s    = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111, 3'b001, 3'b010, 3'b000, 3'b101, 3'b000};
    ads    = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    exp_wd = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81, 32'h80F0_7F81,
               32'hFFFF_80F0, 32'h80F0_7F81, 32'h0000_007F, 32'h0000_80F0, 32'hFFFF_FFF0};
    for (int v = 0; v < 10; v++) begin
      ifc.ld_valid  = 1'b1;
      ifc.ld_rd     = 5'd5;
      ifc.ld_data   = 32'h80F0_7F81;
      ifc.ld_funct3 = f3s[v];
      ifc.ld_addr   = ads[v];
      tick();
      ifc.ld_valid = 1'b0;
      total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL ext_early v=%0d en got=%b exp=0", v, ifc.en); end
      tick();
      total++; if (ifc.wd !== exp_wd[v]) begin bad++; $display("FAIL ext_wd v=%0d got=%h exp=%h", v, ifc.wd, exp_wd[v]); end
      total++; if (ifc.wa !== 5'd5 || ifc.en !== 1'b1) begin bad++; $display("FAIL ext_wa_en v=%0d got wa=%0d en=%b exp wa=5 en=1", v, ifc.wa, ifc.en); end
      tick();
    end
  endtask

  task automatic test_priority();
    ifc.chk_adr1 = 5'd7;
    load(5'd7, 32'h77);
    #1;
    total++; if (ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL prio_hit_same_cycle got=%b exp=0", ifc.chk_hit1); end
    tick();
    ifc.ld_valid = 1'b0;
    alu(5'd3, 32'h33);
    total++; if (ifc.chk_hit1 !== 1'b1) begin bad++; $display("FAIL prio_hit_n1 got=%b exp=1", ifc.chk_hit1); end
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL prio_en_n1 got=%b exp=0", ifc.en); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (k == 4) ifc.alu_valid = 1'b0;
      total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'd3 || ifc.wd !== 32'h33) begin bad++; $display("FAIL prio_alu k=%0d got en=%b wa=%0d wd=%h exp en=1 wa=3 wd=33", k, ifc.en, ifc.wa, ifc.wd); end
      total++; if (ifc.chk_hit1 !== 1'b1) begin bad++; $display("FAIL prio_hit k=%0d got=%b exp=1", k, ifc.chk_hit1); end
    end
    tick();
    total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'd7 || ifc.wd !== 32'h77) begin bad++; $display("FAIL prio_ld got en=%b wa=%0d wd=%h exp en=1 wa=7 wd=77", ifc.en, ifc.wa, ifc.wd); end
    total++; if (ifc.chk_hit1 !== 1'b1) begin bad++; $display("FAIL prio_hit_n5 got=%b exp=1", ifc.chk_hit1); end
    tick();
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL prio_idle en got=%b exp=0", ifc.en); end
    total++; if (ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL prio_hit_n6 got=%b exp=0", ifc.chk_hit1); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] d;
    for (int rep = 0; rep < 3; rep++) begin
      alu(5'd2, 32'(rep));
      for (int j = 0; j < 4; j++) begin
        total++; if (ifc.ld_ready !== 1'b1) begin bad++; $display("FAIL full_ready_fill r=%0d j=%0d got=%b exp=1", rep, j, ifc.ld_ready); end
        load(5'(8 + j), 32'h100 * 32'(rep) + 32'(j));
        tick();
      end
      total++; if (ifc.ld_ready !== 1'b0 || ifc.wb_full !== 1'b1) begin bad++; $display("FAIL full_flags r=%0d got ready=%b full=%b exp ready=0 full=1", rep, ifc.ld_ready, ifc.wb_full); end
      load(5'd20, 32'hDEAD);
      tick();
      ifc.ld_valid  = 1'b0;
      ifc.alu_valid = 1'b0;
      total++; if (ifc.ld_ready !== 1'b0) begin bad++; $display("FAIL full_hold r=%0d got=%b exp=0", rep, ifc.ld_ready); end
      tick();
      total++; if (ifc.ld_ready !== 1'b1 || ifc.wb_full !== 1'b0) begin bad++; $display("FAIL full_release r=%0d got ready=%b full=%b exp ready=1 full=0", rep, ifc.ld_ready, ifc.wb_full); end
      for (int j = 0; j < 4; j++) begin
        if (j > 0) tick();
        d = 32'h100 * 32'(rep) + 32'(j);
        total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'(8 + j) || ifc.wd !== d) begin bad++; $display("FAIL full_order r=%0d j=%0d got en=%b wa=%0d wd=%h exp en=1 wa=%0d wd=%h", rep, j, ifc.en, ifc.wa, ifc.wd, 8 + j, d); end
      end
      tick();
      total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL full_drained r=%0d en got=%b exp=0 wa=%0d", rep, ifc.en, ifc.wa); end
    end
  endtask

  task automatic test_x0();
    ifc.chk_adr1 = 5'd0;
    ifc.chk_adr2 = 5'd9;
    alu(5'd0, 32'h55);
    load(5'd0, 32'h99);
    tick();
    load(5'd9, 32'h909);
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL x0_alu_en got=%b exp=0", ifc.en); end
    total++; if (ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL x0_hit1 got=%b exp=0", ifc.chk_hit1); end
    tick();
    load(5'd10, 32'hA0A);
    total++; if (ifc.chk_hit2 !== 1'b1) begin bad++; $display("FAIL x0_hit2_queued got=%b exp=1", ifc.chk_hit2); end
    tick();
    load(5'd11, 32'hB0B);
    tick();
    ifc.ld_valid  = 1'b0;
    ifc.alu_valid = 1'b0;
    total++; if (ifc.ld_ready !== 1'b0) begin bad++; $display("FAIL x0_slot ld_ready got=%b exp=0", ifc.ld_ready); end
    total++; if (ifc.en !== 1'b0 || ifc.chk_hit1 !== 1'b0) begin bad++; $display("FAIL x0_alu_hold got en=%b hit1=%b exp 0 0", ifc.en, ifc.chk_hit1); end
    tick();
    total++; if (ifc.en !== 1'b0 || ifc.wa !== 5'd0 || ifc.wd !== 32'h99) begin bad++; $display("FAIL x0_ld_pop got en=%b wa=%0d wd=%h exp en=0 wa=0 wd=99", ifc.en, ifc.wa, ifc.wd); end
    total++; if (ifc.ld_ready !== 1'b1) begin bad++; $display("FAIL x0_ready_back got=%b exp=1", ifc.ld_ready); end
    tick();
    total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'd9 || ifc.wd !== 32'h909) begin bad++; $display("FAIL x0_next got en=%b wa=%0d wd=%h exp en=1 wa=9 wd=909", ifc.en, ifc.wa, ifc.wd); end
    total++; if (ifc.chk_hit2 !== 1'b1) begin bad++; $display("FAIL x0_hit2_wr got=%b exp=1", ifc.chk_hit2); end
    tick();
    total++; if (ifc.wa !== 5'd10 || ifc.chk_hit2 !== 1'b0) begin bad++; $display("FAIL x0_after got wa=%0d hit2=%b exp wa=10 hit2=0", ifc.wa, ifc.chk_hit2); end
    tick();
    total++; if (ifc.wa !== 5'd11 || ifc.en !== 1'b1) begin bad++; $display("FAIL x0_last got wa=%0d en=%b exp wa=11 en=1", ifc.wa, ifc.en); end
    tick();
  endtask

  task automatic test_push_pop();
    alu(5'd1, 32'hA1);
    load(5'd12, 32'hC12);
    tick();
    load(5'd13, 32'hC13);
    tick();
    ifc.alu_valid = 1'b0;
    load(5'd14, 32'hC14);
    tick();
    total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'd12 || ifc.wd !== 32'hC12) begin bad++; $display("FAIL pp_head got en=%b wa=%0d wd=%h exp en=1 wa=12 wd=c12", ifc.en, ifc.wa, ifc.wd); end
    alu(5'd1, 32'hA1);
    load(5'd15, 32'hC15);
    tick();
    total++; if (ifc.ld_ready !== 1'b1) begin bad++; $display("FAIL pp_count3 ld_ready got=%b exp=1", ifc.ld_ready); end
    load(5'd16, 32'hC16);
    tick();
    total++; if (ifc.ld_ready !== 1'b0 || ifc.wb_full !== 1'b1) begin bad++; $display("FAIL pp_count4 got ready=%b full=%b exp ready=0 full=1", ifc.ld_ready, ifc.wb_full); end
    ifc.ld_valid  = 1'b0;
    ifc.alu_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      total++; if (ifc.en !== 1'b1 || ifc.wa !== 5'(13 + j) || ifc.wd !== 32'hC13 + 32'(j)) begin bad++; $display("FAIL pp_order j=%0d got en=%b wa=%0d wd=%h exp en=1 wa=%0d", j, ifc.en, ifc.wa, ifc.wd, 13 + j); end
    end
    tick();
    total++; if (ifc.en !== 1'b0) begin bad++; $display("FAIL pp_drained en got=%b exp=0", ifc.en); end
  endtask

  initial begin
    idle();
    ifc.chk_adr1 = 5'd0;
    ifc.chk_adr2 = 5'd0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_reset_midstream();
    idle();
    tick();
    test_extension();
    idle();
    tick();
    tick();
    test_priority();
    idle();
    tick();
    test_full_wrap();
    idle();
    tick();
    test_x0();
    idle();
    tick();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
